dm_sba_ctrl: RTL

DM_SBA_CTRL -- requirements
Module: dm_sba_ctrl

---
 rtl/dm_sba_ctrl_if.sv | 28 ++
 rtl/dm_sba_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dm_sba_ctrl_if.sv
// System-bus master channel of the debug-module SBA controller.
// The master drives the request side and the slave answers with grant/response.
interface dm_sba_ctrl_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req_o;
  logic                 we_o;
  logic [AddrWidth-1:0] addr_o;
  logic [DataWidth-1:0] wdata_o;
  logic [BeWidth-1:0]   be_o;
  logic                 gnt_i;
  logic                 rvalid_i;
  logic [DataWidth-1:0] rdata_i;
  logic                 err_i;

  modport master (
    output req_o, we_o, addr_o, wdata_o, be_o,
    input  gnt_i, rvalid_i, rdata_i, err_i
  );

  modport slave (
    input  req_o, we_o, addr_o, wdata_o, be_o,
    output gnt_i, rvalid_i, rdata_i, err_i
  );
endinterface

// File: rtl/dm_sba_ctrl.sv
// RISC-V debug-module system bus access controller: turns sbaddress/sbdata
// register activity into single bus transactions and tracks sberror/sbbusyerror.
module dm_sba_ctrl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] sbaddress_i,
  input  logic                 sbaddress_we_i,
  input  logic [DataWidth-1:0] sbdata_i,
  input  logic                 sbdata_we_i,
  input  logic                 sbdata_re_i,
  input  logic [4:0]           sbcs_i,
  input  logic                 sberror_clr_i,
  input  logic                 sbbusyerror_clr_i,
  output logic [AddrWidth-1:0] sbaddress_o,
  output logic [DataWidth-1:0] sbdata_o,
  output logic                 sbbusy_o,
  output logic                 sbbusyerror_o,
  output logic [2:0]           sberror_o,
  dm_sba_ctrl_if.master        bus
);
  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    READ       = 3'b001,
    WRITE      = 3'b010,
    WAIT_READ  = 3'b011,
    WAIT_WRITE = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           size_q, size_d;
  logic                 autoinc_q, autoinc_d;
  logic [AddrWidth-1:0] sbaddress_d;
  logic [DataWidth-1:0] sbdata_d;
  logic [2:0]           sberror_d;
  logic                 sbbusyerror_d;
  logic                 req_d, we_d;
  logic [AddrWidth-1:0] addr_d;
  logic [BeWidth-1:0]   be_d;
  logic [DataWidth-1:0] wdata_d;

  // Trigger qualification is evaluated against the address as it will be after this cycle's load.
  logic                 trigger_rd, trigger_wr, trig, misaligned, access_err, align_err, start;
  logic [AddrWidth-1:0] addr_n;
  logic [DataWidth-1:0] rdata_shift, rdata_ext;
  logic [AddrWidth-1:0] incr;

  assign trigger_rd = (sbaddress_we_i & sbcs_i[4]) | (sbdata_re_i & sbcs_i[3]);
  assign trigger_wr = sbdata_we_i;
  assign addr_n     = sbaddress_we_i ? sbaddress_i : sbaddress_o;
  assign misaligned = ((sbcs_i[1:0] == 2'd1) && addr_n[0]) ||
                      ((sbcs_i[1:0] == 2'd2) && (addr_n[1:0] != 2'd0));
  assign trig       = (state_q == IDLE) && (sberror_o == 3'd0) && !sbbusyerror_o &&
                      (trigger_rd || trigger_wr);
  assign access_err = trig && (sbcs_i[1:0] == 2'd3);
  assign align_err  = trig && !access_err && misaligned;
  assign start      = trig && !access_err && !misaligned;

  assign rdata_shift = bus.rdata_i >> {sbaddress_o[1:0], 3'b000};
  assign incr        = AddrWidth'(1) << size_q;

  always_comb begin
    unique case (size_q)
      2'd0:    rdata_ext = DataWidth'(rdata_shift[7:0]);
      2'd1:    rdata_ext = DataWidth'(rdata_shift[15:0]);
      default: rdata_ext = rdata_shift;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      size_q        <= 2'd0;
      autoinc_q     <= 1'b0;
      sbaddress_o   <= '0;
      sbdata_o      <= '0;
      sberror_o     <= 3'd0;
      sbbusyerror_o <= 1'b0;
      sbbusy_o      <= 1'b0;
      bus.req_o     <= 1'b0;
      bus.we_o      <= 1'b0;
      bus.addr_o    <= '0;
      bus.be_o      <= '0;
      bus.wdata_o   <= '0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      autoinc_q     <= autoinc_d;
      sbaddress_o   <= sbaddress_d;
      sbdata_o      <= sbdata_d;
      sberror_o     <= sberror_d;
      sbbusyerror_o <= sbbusyerror_d;
      sbbusy_o      <= (state_d != IDLE);
      bus.req_o     <= req_d;
      bus.we_o      <= we_d;
      bus.addr_o    <= addr_d;
      bus.be_o      <= be_d;
      bus.wdata_o   <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = trigger_wr ? WRITE : READ;
      READ:       if (bus.gnt_i) state_d = WAIT_READ;
      WRITE:      if (bus.gnt_i) state_d = WAIT_WRITE;
      WAIT_READ,
      WAIT_WRITE: if (bus.rvalid_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of the debugger-visible registers and the registered bus request.
  always_comb begin
    logic       err_set;
    logic [2:0] err_val;
    logic       busy_set;
    sbaddress_d = sbaddress_o;
    sbdata_d    = sbdata_o;
    size_d      = size_q;
    autoinc_d   = autoinc_q;
    err_set     = 1'b0;
    err_val     = 3'd0;
    busy_set    = 1'b0;
    if (state_q == IDLE) begin
      if (sbaddress_we_i) sbaddress_d = sbaddress_i;
      if (sbdata_we_i)    sbdata_d    = sbdata_i;
      if (start) begin
        size_d    = sbcs_i[1:0];
        autoinc_d = sbcs_i[2];
      end
      if (access_err) begin
        err_set = 1'b1;
        err_val = 3'd4;
      end else if (align_err) begin
        err_set = 1'b1;
        err_val = 3'd3;
      end
    end else begin
      busy_set = sbaddress_we_i | sbdata_we_i | sbdata_re_i;
      if (((state_q == WAIT_READ) || (state_q == WAIT_WRITE)) && bus.rvalid_i) begin
        if (bus.err_i) begin
          err_set = 1'b1;
          err_val = 3'd2;
        end else begin
          if (state_q == WAIT_READ) sbdata_d = rdata_ext;
          if (autoinc_q) sbaddress_d = sbaddress_o + incr;
        end
      end
    end
    sberror_d     = err_set ? err_val : (sberror_clr_i ? 3'd0 : sberror_o);
    sbbusyerror_d = busy_set | (sbbusyerror_o & ~sbbusyerror_clr_i);

    req_d   = (state_d == READ) || (state_d == WRITE);
    we_d    = (state_d == WRITE);
    addr_d  = {sbaddress_d[AddrWidth-1:2], 2'b00};
    unique case (size_d)
      2'd0:    be_d = BeWidth'(4'b0001) << sbaddress_d[1:0];
      2'd1:    be_d = BeWidth'(4'b0011) << sbaddress_d[1:0];
      2'd2:    be_d = BeWidth'(4'b1111) << sbaddress_d[1:0];
      default: be_d = '0;
    endcase
    wdata_d = sbdata_d << {sbaddress_d[1:0], 3'b000};
  end
endmodule
